// File: rtl/fp_normalize_controller.sv
// FP add/sub normalization control: iterative leading-zero scan with exponent clamp.
// Define NORM_CTRL_FAST_LZC_EN for a single-cycle combinational leading-zero count.
module fp_normalize_controller #(
  parameter int MENT_WIDTH      = 23,
  parameter int EXPO_WIDTH      = 8,
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MENT_WIDTH:0]         addition_in,
  input  logic                        carry_in,
  input  logic [EXPO_WIDTH-1:0]       bigger_exponent_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(MENT_WIDTH):0] normalize_position_out,
  output logic                        right_shift_out,
  output logic                        zero_result_out,
  output logic                        underflow_out,
  output logic                        overflow_out
);

  localparam int SW  = MENT_WIDTH + 1;
  localparam int PW  = $clog2(MENT_WIDTH) + 1;
  localparam int CW  = ((PW > EXPO_WIDTH) ? PW : EXPO_WIDTH) + 1;
  localparam int SPC = SHIFT_PER_CYCLE;
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX = {{(EXPO_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e state_q, state_d;
  logic [SW-1:0]         work_q, work_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [EXPO_WIDTH-1:0] exp_q, exp_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic rs_q, rs_d, zr_q, zr_d, uf_q, uf_d, of_q, of_d;

  // {hit, index of first 1 counted from the MSB} over the top SPC bits
  function automatic logic [PW:0] win_scan(input logic [SW-1:0] v);
    logic [PW:0] r;
    r = '0;
    for (int i = SPC - 1; i >= 0; i--)
      if (v[SW-1-i]) r = {1'b1, PW'(i)};
    return r;
  endfunction

  function automatic logic [PW:0] clamp(
    input logic [PW-1:0]         fin,
    input logic [EXPO_WIDTH-1:0] e
  );
    logic [CW-1:0] lim;
    lim = (e != '0) ? CW'(e) - CW'(1) : '0;
    if (CW'(fin) > lim) return {1'b1, lim[PW-1:0]};
    return {1'b0, fin};
  endfunction

`ifdef NORM_CTRL_FAST_LZC_EN
  function automatic logic [PW-1:0] lzc(input logic [SW-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++)
      if (v[i]) r = PW'(SW - 1 - i);
    return r;
  endfunction
`else
  logic [PW:0] acc_win;
  assign acc_win = win_scan(addition_in);
`endif

  logic [PW:0] scan_win;
  assign scan_win = win_scan(work_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      pos_q   <= '0;
      rs_q    <= 1'b0;
      zr_q    <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      pos_q   <= pos_d;
      rs_q    <= rs_d;
      zr_q    <= zr_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) begin
`ifdef NORM_CTRL_FAST_LZC_EN
        state_d = DONE;
`else
        // the first window is examined in the accept cycle itself
        state_d = (carry_in || addition_in == '0 || acc_win[PW])
                  ? DONE : SCAN;
`endif
      end
      SCAN: if (scan_win[PW]) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    exp_d  = exp_q;
    pos_d  = pos_q;
    rs_d   = rs_q;
    zr_d   = zr_q;
    uf_d   = uf_q;
    of_d   = of_q;
    case (state_q)
      IDLE: if (in_valid) begin
        work_d = addition_in << SPC;
        cnt_d  = PW'(SPC);
        exp_d  = bigger_exponent_in;
        rs_d   = carry_in;
        zr_d   = 1'b0;
        uf_d   = 1'b0;
        of_d   = carry_in && (bigger_exponent_in == EXP_MAX);
        if (carry_in || addition_in == '0) begin
          pos_d = '0;
          zr_d  = !carry_in;
        end
`ifdef NORM_CTRL_FAST_LZC_EN
        else {uf_d, pos_d} = clamp(lzc(addition_in), bigger_exponent_in);
`else
        else if (acc_win[PW])
          {uf_d, pos_d} = clamp(acc_win[PW-1:0], bigger_exponent_in);
`endif
      end
      SCAN: begin
        if (scan_win[PW]) begin
          {uf_d, pos_d} = clamp(cnt_q + scan_win[PW-1:0], exp_q);
        end else begin
          cnt_d  = cnt_q + PW'(SPC);
          work_d = work_q << SPC;
        end
      end
      DONE: if (out_ready) begin
        rs_d = 1'b0;
        zr_d = 1'b0;
        uf_d = 1'b0;
        of_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign normalize_position_out = pos_q;
  assign right_shift_out        = rs_q;
  assign zero_result_out        = zr_q;
  assign underflow_out          = uf_q;
  assign overflow_out           = of_q;

endmodule

// File: tb/tb_fp_normalize_controller.sv
// Directed bench for fp_normalize_controller with a spec-level reference model.
module tb_fp_normalize_controller;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] addition_in = '0;
  logic        carry_in = 1'b0;
  logic [7:0]  bigger_exponent_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  pos;
  logic        rs, zr, uf, of;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  bit first = 1'b1;
  logic [5:0] last_pos = '0;

  typedef struct {
    logic [5:0] pos;
    bit rs; bit zr; bit uf; bit of;
    int lat; int acc;
  } exp_t;

  typedef struct {
    logic [23:0] s; logic c; logic [7:0] e;
  } vec_t;

  exp_t q[$];
  exp_t ce;

  fp_normalize_controller #(
    .MENT_WIDTH(23), .EXPO_WIDTH(8), .SHIFT_PER_CYCLE(S)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .addition_in(addition_in), .carry_in(carry_in),
    .bigger_exponent_in(bigger_exponent_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .normalize_position_out(pos),
    .right_shift_out(rs), .zero_result_out(zr),
    .underflow_out(uf), .overflow_out(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // leading zeros from the MSB, clamp against exp-1, latency per scan rules
  function automatic exp_t model(input logic [23:0] s, input logic c,
                                 input logic [7:0] e);
    exp_t r;
    int z, lim;
    r = '{default: 0};
    r.lat = 1;
    if (c) begin
      r.rs = 1'b1;
      r.of = (e == 8'd254);
      return r;
    end
    if (s == 0) begin
      r.zr = 1'b1;
      return r;
    end
    z = 0;
    while (s[23-z] == 1'b0) z++;
    lim = (e >= 1) ? int'(e) - 1 : 0;
    r.uf  = (z > lim);
    r.pos = 6'((z > lim) ? lim : z);
`ifndef NORM_CTRL_FAST_LZC_EN
    r.lat = z / S + 1;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        ce = q[0];
        chk("position", pos, ce.pos);
        chk("right_shift", rs, ce.rs);
        chk("zero_result", zr, ce.zr);
        chk("underflow", uf, ce.uf);
        chk("overflow", of, ce.of);
        chk("in_ready_busy", in_ready, 0);
        if (first) chk("latency", cyc - ce.acc + 1, ce.lat);
        if (out_ready) begin
          last_pos = ce.pos;
          void'(q.pop_front());
          first = 1'b1;
        end else begin
          first = 1'b0;
        end
      end
    end
  end

  task automatic start(input logic [23:0] s, input logic c, input logic [7:0] e);
    int n;
    exp_t x;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    addition_in = s;
    carry_in = c;
    bigger_exponent_in = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = model(s, c, e);
    x.acc = cyc;
    q.push_back(x);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
      return;
    end
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("flags_cleared", {rs, zr, uf, of}, 0);
    chk("position_hold", pos, last_pos);
  endtask

  vec_t vt [13] = '{
    '{24'h800000, 1'b0, 8'd100},
    '{24'h000100, 1'b0, 8'd100},
    '{24'h400000, 1'b1, 8'd254},
    '{24'h400000, 1'b1, 8'd100},
    '{24'h000000, 1'b0, 8'd50},
    '{24'h000001, 1'b0, 8'd5},
    '{24'h000001, 1'b0, 8'd0},
    '{24'h000008, 1'b0, 8'd200},
    '{24'h000100, 1'b0, 8'd16},
    '{24'h000100, 1'b0, 8'd15},
    '{24'h200000, 1'b0, 8'd1},
    '{24'h000000, 1'b1, 8'd7},
    '{24'h000000, 1'b0, 8'd0}
  };

  initial begin
    exp_t m;
    int n;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_position", pos, 0);
    chk("reset_flags", {rs, zr, uf, of}, 0);
    rst = 1'b0;

    m = model(24'h000100, 1'b0, 8'd100);
    chk("model_pos_z15", m.pos, 15);
`ifndef NORM_CTRL_FAST_LZC_EN
    chk("model_lat_z15", m.lat, 4);
`endif
    m = model(24'h000001, 1'b0, 8'd5);
    chk("model_pos_clamp", m.pos, 4);
    chk("model_uf_clamp", m.uf, 1);
    m = model(24'h400000, 1'b1, 8'd254);
    chk("model_overflow", m.of, 1);

    for (int i = 0; i < 13; i++) begin
      start(vt[i].s, vt[i].c, vt[i].e);
      wait_done();
    end

    out_ready = 1'b0;
    start(24'h000100, 1'b0, 8'd100);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_done", out_valid, 1);
    in_valid = 1'b1;
    addition_in = 24'h000003;
    carry_in = 1'b0;
    bigger_exponent_in = 8'd9;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    start(24'h000001, 1'b0, 8'd100);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    first = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    last_pos = '0;
    repeat (8) @(posedge clk);
    #1;

    start(24'h800000, 1'b0, 8'd100);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
